// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic skew/deskew buffer.
// Lane delay mapping, drain-counter width and the drain FSM state encoding.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } skew_state_t;

    localparam int DEF_ROWS  = 16;
    localparam int DEF_CNT_W = $clog2(DEF_ROWS);

    // Skew puts lane 0 first; deskew reverses the diagonal so lane ROWS-1 is first.
    function automatic int lane_delay(input int r, input int rows, input bit deskew);
        return deskew ? (rows - 1 - r) : r;
    endfunction

    function automatic int cnt_width(input int rows);
        return $clog2(rows);
    endfunction

endpackage

// File: rtl/skew_lane.sv
// One lane of the skew buffer: a DEPTH-stage delay line of {data, valid, last}.
// DEPTH = 0 degenerates to a combinational passthrough of the accepted beat.
module skew_lane
    import systolic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             CLK,
    input  logic             ASYNC_RST,
    input  logic             clr_i,
    input  logic             adv_i,
    input  logic             acc_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             last_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             last_o
);

    if (DEPTH == 0) begin : g_pass
        // Clock/reset/advance are irrelevant here; acc already folds them in.
        logic unused;
        assign unused  = ^{CLK, ASYNC_RST, clr_i, adv_i};
        assign data_o  = acc_i ? data_i : '0;
        assign valid_o = acc_i;
        assign last_o  = acc_i & last_i;
    end else begin : g_line
        logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
        logic [DEPTH-1:0]            vld_q, vld_d;
        logic [DEPTH-1:0]            last_q, last_d;

        always_comb begin
            data_d = data_q;
            vld_d  = vld_q;
            last_d = last_q;
            if (adv_i) begin
                // Non-accepted cycles inject a zero bubble so the PEs add nothing.
                data_d[0] = acc_i ? data_i : '0;
                vld_d[0]  = acc_i;
                last_d[0] = acc_i & last_i;
                for (int s = 1; s < DEPTH; s++) begin
                    data_d[s] = data_q[s-1];
                    vld_d[s]  = vld_q[s-1];
                    last_d[s] = last_q[s-1];
                end
            end
        end

        always_ff @(posedge CLK or negedge ASYNC_RST) begin
            if (!ASYNC_RST) begin
                data_q <= '0;
                vld_q  <= '0;
                last_q <= '0;
            end else if (clr_i) begin
                data_q <= '0;
                vld_q  <= '0;
                last_q <= '0;
            end else begin
                data_q <= data_d;
                vld_q  <= vld_d;
                last_q <= last_d;
            end
        end

        // Outputs read zero for the whole cycle a synchronous clear is applied.
        assign data_o  = clr_i ? '0 : data_q[DEPTH-1];
        assign valid_o = ~clr_i & vld_q[DEPTH-1];
        assign last_o  = ~clr_i & last_q[DEPTH-1];
    end

endmodule

// File: rtl/systolic_skew_buffer.sv
// Diagonal alignment buffer for the systolic array: per-lane delay lines plus
// a drain FSM that closes the input while a tile flushes and pulses DONE.
module systolic_skew_buffer
    import systolic_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ROWS   = 16,
    parameter bit DESKEW = 1'b0
) (
    input  logic                       CLK,
    input  logic                       ASYNC_RST,
    input  logic                       SYNC_RST,
    input  logic                       STALL,
    input  logic                       IN_VALID,
    input  logic                       IN_LAST,
    output logic                       IN_READY,
    input  logic [0:ROWS-1][WIDTH-1:0] IN_DATA,
    output logic [0:ROWS-1][WIDTH-1:0] OUT_DATA,
    output logic [0:ROWS-1]            OUT_VALID,
    output logic [0:ROWS-1]            OUT_LAST,
    output logic                       BUSY,
    output logic                       DONE
);

    localparam int CNT_W = cnt_width(ROWS);

    skew_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             adv, acc;

    assign adv      = ~STALL;
    assign IN_READY = ASYNC_RST & ~SYNC_RST & ~STALL & (state_q != DRAIN);
    assign acc      = IN_VALID & IN_READY;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, STREAM: begin
                if (acc) begin
                    if (IN_LAST) begin
                        // ROWS-1 closed cycles: ROWS-2 down to 0 inclusive.
                        state_d = DRAIN;
                        cnt_d   = CNT_W'(ROWS - 2);
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            DRAIN: begin
                if (adv) begin
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (SYNC_RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (adv) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign DONE = (state_q == DRAIN) & (cnt_q == '0) & adv & ~SYNC_RST;
    assign BUSY = (state_q != IDLE) & ~SYNC_RST;

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        localparam int DLY = lane_delay(r, ROWS, DESKEW);
        skew_lane #(
            .WIDTH (WIDTH),
            .DEPTH (DLY)
        ) u_lane (
            .CLK       (CLK),
            .ASYNC_RST (ASYNC_RST),
            .clr_i     (SYNC_RST),
            .adv_i     (adv),
            .acc_i     (acc),
            .data_i    (IN_DATA[r]),
            .last_i    (IN_LAST),
            .data_o    (OUT_DATA[r]),
            .valid_o   (OUT_VALID[r]),
            .last_o    (OUT_LAST[r])
        );
    end

endmodule

// File: tb/tb_systolic_skew_buffer.sv
// Bench: skew ROWS=4, deskew ROWS=4 and skew ROWS=2 instances share stimulus and
// are checked every cycle against a queue-based beat-history model.
module tb_systolic_skew_buffer;

    typedef struct packed {
        logic            v;
        logic            l;
        logic [0:3][7:0] d;
    } beat_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic            ASYNC_RST = 1'b0, SYNC_RST = 1'b0, STALL = 1'b0;
    logic            IN_VALID = 1'b0, IN_LAST = 1'b0;
    logic [0:3][7:0] in_d = '0;

    logic [0:3][7:0] o0_d, o1_d;
    logic [0:1][7:0] o2_d;
    logic [0:3]      o0_v, o0_l, o1_v, o1_l;
    logic [0:1]      o2_v, o2_l;
    logic [2:0]      rdy, busy, done;

    systolic_skew_buffer #(.WIDTH(8), .ROWS(4), .DESKEW(1'b0)) dut0 (
        .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .STALL(STALL),
        .IN_VALID(IN_VALID), .IN_LAST(IN_LAST), .IN_READY(rdy[0]), .IN_DATA(in_d),
        .OUT_DATA(o0_d), .OUT_VALID(o0_v), .OUT_LAST(o0_l), .BUSY(busy[0]), .DONE(done[0]));
    systolic_skew_buffer #(.WIDTH(8), .ROWS(4), .DESKEW(1'b1)) dut1 (
        .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .STALL(STALL),
        .IN_VALID(IN_VALID), .IN_LAST(IN_LAST), .IN_READY(rdy[1]), .IN_DATA(in_d),
        .OUT_DATA(o1_d), .OUT_VALID(o1_v), .OUT_LAST(o1_l), .BUSY(busy[1]), .DONE(done[1]));
    systolic_skew_buffer #(.WIDTH(8), .ROWS(2), .DESKEW(1'b0)) dut2 (
        .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .STALL(STALL),
        .IN_VALID(IN_VALID), .IN_LAST(IN_LAST), .IN_READY(rdy[2]), .IN_DATA(in_d[0:1]),
        .OUT_DATA(o2_d), .OUT_VALID(o2_v), .OUT_LAST(o2_l), .BUSY(busy[2]), .DONE(done[2]));

    logic [0:3][7:0] od [3];
    logic [0:3]      ov [3], ol [3];
    assign od[0] = o0_d;            assign ov[0] = o0_v;          assign ol[0] = o0_l;
    assign od[1] = o1_d;            assign ov[1] = o1_v;          assign ol[1] = o1_l;
    assign od[2] = {o2_d, 16'h0};   assign ov[2] = {o2_v, 2'b00}; assign ol[2] = {o2_l, 2'b00};

    // Reference model state
    int    rows_m [3] = '{4, 4, 2};
    bit    desk_m [3] = '{1'b0, 1'b1, 1'b0};
    beat_t hq [3][$];
    int    dl [3] = '{0, 0, 0};
    bit    strm [3] = '{1'b0, 1'b0, 1'b0};

    logic [0:3][7:0] ed [3];
    logic [0:3]      ev [3], el [3];
    logic [2:0]      er, eb, en;

    int npass = 0, nchk = 0;

    // Drive one cycle at the falling edge, then compute this cycle's expectations
    // and advance the model to its post-rising-edge state.
    task automatic step(input logic v, input logic l, input logic [0:3][7:0] d,
                        input logic st, input logic sr, input logic ar);
        logic  rst, acc;
        int    dly;
        beat_t b;
        @(negedge CLK);
        IN_VALID = v; IN_LAST = l; in_d = d; STALL = st; SYNC_RST = sr; ASYNC_RST = ar;
        #1;
        rst = !ar || sr;
        for (int u = 0; u < 3; u++) begin
            er[u] = ar && !sr && !st && (dl[u] == 0);
            acc   = v && er[u];
            ed[u] = '0; ev[u] = '0; el[u] = '0;
            if (!rst) begin
                for (int r = 0; r < rows_m[u]; r++) begin
                    dly = desk_m[u] ? rows_m[u] - 1 - r : r;
                    if (dly == 0) begin
                        if (acc) begin ed[u][r] = d[r]; ev[u][r] = 1'b1; el[u][r] = l; end
                    end else if (hq[u].size() >= dly) begin
                        b = hq[u][dly-1];
                        ed[u][r] = b.d[r]; ev[u][r] = b.v; el[u][r] = b.l;
                    end
                end
            end
            en[u] = !rst && !st && (dl[u] == 1);
            eb[u] = !rst && (strm[u] || dl[u] > 0);
            if (rst) begin
                hq[u].delete(); dl[u] = 0; strm[u] = 1'b0;
            end else if (!st) begin
                b.v = acc; b.l = acc && l; b.d = acc ? d : '0;
                hq[u].push_front(b);
                if (hq[u].size() > 4) void'(hq[u].pop_back());
                if (acc && l) begin dl[u] = rows_m[u] - 1; strm[u] = 1'b0; end
                else if (acc) strm[u] = 1'b1;
                else if (dl[u] > 0) dl[u]--;
            end
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 1'b0, 32'hA5A5_A5A5, 1'b0, c == 2, c != 0 && c != 1);
            for (int u = 0; u < 3; u++) begin
                nchk++;
                if ({od[u], ov[u], ol[u]} !== {ed[u], ev[u], el[u]})
                    $display("FAIL reset lanes dut%0d c%0d: got %h/%b/%b want %h/%b/%b", u, c, od[u], ov[u], ol[u], ed[u], ev[u], el[u]);
                else npass++;
                nchk++;
                if ({rdy[u], busy[u], done[u]} !== {er[u], eb[u], en[u]})
                    $display("FAIL reset ctl dut%0d c%0d: got %b want %b", u, c, {rdy[u], busy[u], done[u]}, {er[u], eb[u], en[u]});
                else npass++;
            end
        end
        // Let the stream from c=3 settle into idle
        for (int c = 0; c < 6; c++) step(1'b1, c == 0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_wavefront();
        logic [0:3][7:0] d;
        int dc0 = -1, dc1 = -1;
        for (int c = 0; c < 10; c++) begin
            for (int r = 0; r < 4; r++) d[r] = 8'(16 * c + r);
            step(c < 4, c == 3, d, 1'b0, 1'b0, 1'b1);
            for (int u = 0; u < 3; u++) begin
                nchk++;
                if ({od[u], ov[u], ol[u]} !== {ed[u], ev[u], el[u]})
                    $display("FAIL wave lanes dut%0d c%0d: got %h/%b/%b want %h/%b/%b", u, c, od[u], ov[u], ol[u], ed[u], ev[u], el[u]);
                else npass++;
                nchk++;
                if ({rdy[u], busy[u], done[u]} !== {er[u], eb[u], en[u]})
                    $display("FAIL wave ctl dut%0d c%0d: got %b want %b", u, c, {rdy[u], busy[u], done[u]}, {er[u], eb[u], en[u]});
                else npass++;
            end
            if (done[0] && dc0 < 0) dc0 = c;
            if (done[1] && dc1 < 0) dc1 = c;
        end
        nchk++;
        if (dc0 !== 6) $display("FAIL wave skew done cycle: got %0d want 6", dc0); else npass++;
        nchk++;
        if (dc1 !== 6) $display("FAIL wave deskew done cycle: got %0d want 6", dc1); else npass++;
    endtask

    task automatic test_stall();
        logic [0:3][7:0] d;
        logic st;
        int k = 0, dc0 = -1;
        for (int c = 0; c < 12; c++) begin
            st = (c == 2 || c == 3);
            for (int r = 0; r < 4; r++) d[r] = 8'(16 * k + r);
            step(k < 4, k == 3, d, st, 1'b0, 1'b1);
            for (int u = 0; u < 3; u++) begin
                nchk++;
                if ({od[u], ov[u], ol[u]} !== {ed[u], ev[u], el[u]})
                    $display("FAIL stall lanes dut%0d c%0d: got %h/%b/%b want %h/%b/%b", u, c, od[u], ov[u], ol[u], ed[u], ev[u], el[u]);
                else npass++;
                nchk++;
                if ({rdy[u], busy[u], done[u]} !== {er[u], eb[u], en[u]})
                    $display("FAIL stall ctl dut%0d c%0d: got %b want %b", u, c, {rdy[u], busy[u], done[u]}, {er[u], eb[u], en[u]});
                else npass++;
            end
            if (done[0] && dc0 < 0) dc0 = c;
            if (k < 4 && !st) k++;
        end
        nchk++;
        if (dc0 !== 8) $display("FAIL stall done cycle: got %0d want 8", dc0); else npass++;
    endtask

    task automatic test_bubbles();
        logic [0:3][7:0] d;
        int dc0 = -1, dc2 = -1;
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 4; r++) d[r] = 8'($urandom_range(1, 255));
            step(c == 0 || c == 2, c == 2, d, 1'b0, 1'b0, 1'b1);
            for (int u = 0; u < 3; u++) begin
                nchk++;
                if ({od[u], ov[u], ol[u]} !== {ed[u], ev[u], el[u]})
                    $display("FAIL bubble lanes dut%0d c%0d: got %h/%b/%b want %h/%b/%b", u, c, od[u], ov[u], ol[u], ed[u], ev[u], el[u]);
                else npass++;
                nchk++;
                if ({rdy[u], busy[u], done[u]} !== {er[u], eb[u], en[u]})
                    $display("FAIL bubble ctl dut%0d c%0d: got %b want %b", u, c, {rdy[u], busy[u], done[u]}, {er[u], eb[u], en[u]});
                else npass++;
            end
            if (done[0] && dc0 < 0) dc0 = c;
            if (done[2] && dc2 < 0) dc2 = c;
        end
        nchk++;
        if (dc0 !== 5) $display("FAIL bubble done cycle rows4: got %0d want 5", dc0); else npass++;
        nchk++;
        if (dc2 !== 3) $display("FAIL bubble done cycle rows2: got %0d want 3", dc2); else npass++;
    endtask

    task automatic test_reset_abort();
        logic [0:3][7:0] d;
        int ndone = 0, dc0 = -1;
        for (int c = 0; c < 23; c++) begin
            d = $urandom();
            step(c < 3 || c == 8 || c == 9 || (c >= 12 && c <= 15), c == 2 || c == 15,
                 d, 1'b0, c == 4, c != 10);
            for (int u = 0; u < 3; u++) begin
                nchk++;
                if ({od[u], ov[u], ol[u]} !== {ed[u], ev[u], el[u]})
                    $display("FAIL abort lanes dut%0d c%0d: got %h/%b/%b want %h/%b/%b", u, c, od[u], ov[u], ol[u], ed[u], ev[u], el[u]);
                else npass++;
                nchk++;
                if ({rdy[u], busy[u], done[u]} !== {er[u], eb[u], en[u]})
                    $display("FAIL abort ctl dut%0d c%0d: got %b want %b", u, c, {rdy[u], busy[u], done[u]}, {er[u], eb[u], en[u]});
                else npass++;
            end
            if (c >= 3 && c <= 11 && (done[0] || done[1])) ndone++;
            if (c >= 12 && done[0] && dc0 < 0) dc0 = c;
        end
        nchk++;
        if (ndone !== 0) $display("FAIL abort spurious done: got %0d want 0", ndone); else npass++;
        nchk++;
        if (dc0 !== 18) $display("FAIL abort next tile done cycle: got %0d want 18", dc0); else npass++;
    endtask

    task automatic test_rows2();
        int dc2 = -1, nlow = 0, lowc = -1;
        for (int c = 0; c < 10; c++) begin
            step(c == 5, c == 5, 32'h1122_3344, 1'b0, 1'b0, 1'b1);
            for (int u = 0; u < 3; u++) begin
                nchk++;
                if ({od[u], ov[u], ol[u]} !== {ed[u], ev[u], el[u]})
                    $display("FAIL rows2 lanes dut%0d c%0d: got %h/%b/%b want %h/%b/%b", u, c, od[u], ov[u], ol[u], ed[u], ev[u], el[u]);
                else npass++;
                nchk++;
                if ({rdy[u], busy[u], done[u]} !== {er[u], eb[u], en[u]})
                    $display("FAIL rows2 ctl dut%0d c%0d: got %b want %b", u, c, {rdy[u], busy[u], done[u]}, {er[u], eb[u], en[u]});
                else npass++;
            end
            if (done[2] && dc2 < 0) dc2 = c;
            if (!rdy[2]) begin nlow++; lowc = c; end
        end
        nchk++;
        if (dc2 !== 6) $display("FAIL rows2 done cycle: got %0d want 6", dc2); else npass++;
        nchk++;
        if (nlow !== 1 || lowc !== 6) $display("FAIL rows2 ready low: got %0d cycles last %0d want 1 at 6", nlow, lowc); else npass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(3) != 0, $urandom_range(5) == 0, $urandom(),
                 $urandom_range(5) == 0, $urandom_range(59) == 0, $urandom_range(99) != 0);
            for (int u = 0; u < 3; u++) begin
                nchk++;
                if ({od[u], ov[u], ol[u]} !== {ed[u], ev[u], el[u]})
                    $display("FAIL random lanes dut%0d c%0d: got %h/%b/%b want %h/%b/%b", u, c, od[u], ov[u], ol[u], ed[u], ev[u], el[u]);
                else npass++;
                nchk++;
                if ({rdy[u], busy[u], done[u]} !== {er[u], eb[u], en[u]})
                    $display("FAIL random ctl dut%0d c%0d: got %b want %b", u, c, {rdy[u], busy[u], done[u]}, {er[u], eb[u], en[u]});
                else npass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_wavefront();
        test_stall();
        test_bubbles();
        test_reset_abort();
        test_rows2();
        test_random();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/systolic_skew_buffer.md
# systolic_skew_buffer

Parametrised input/output alignment buffer for the systolic array. It delays lane `r` by a per-lane number of cycles so row operands enter the PE grid on a diagonal wavefront (skew mode), or realigns diagonal PE results into whole vectors (deskew mode). Each beat carries valid and last tags through the buffer. A drain FSM flushes a tile after its last beat and pulses `DONE` when the tile has fully left the buffer. Downstream back-pressure freezes the whole buffer.

## Interface
- `WIDTH`, 8, data bits per lane.
- `ROWS`, 16, lane count; must be ≥ 2.
- `DESKEW`, 0, lane delay select: 0 gives delay(r) = r; 1 gives delay(r) = ROWS-1-r.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `ASYNC_RST`  in  1  reset, asynchronous, active-low.
- `SYNC_RST`  in  1  synchronous clear, active-high; same effect as `ASYNC_RST`.
- `STALL`  in  1  downstream hold; freezes all state.
- `IN_VALID`  in  1  input beat present.
- `IN_LAST`  in  1  marks the final beat of a tile.
- `IN_READY`  out  1  buffer accepts a beat this cycle.
- `IN_DATA`  in  WIDTH × [0:ROWS-1]  input vector.
- `OUT_DATA`  out  WIDTH × [0:ROWS-1]  aligned lanes.
- `OUT_VALID`  out  [0:ROWS-1]  per-lane valid.
- `OUT_LAST`  out  [0:ROWS-1]  per-lane last tag.
- `BUSY`  out  1  high whenever state ≠ IDLE.
- `DONE`  out  1  single-cycle pulse when the tile is fully emitted.

## Operation
- Definitions:
  - adv = ~STALL.
  - acc = IN_VALID & IN_READY.
  - IN_READY = ASYNC_RST & ~SYNC_RST & ~STALL & (state ≠ DRAIN).
- Lane structure: each lane is a shift line of depth delay(r) holding {data, valid, last}.
  - On each adv edge, every stage takes the value of its upstream neighbour.
  - The entry stage loads {IN_DATA[r], 1, IN_LAST} if acc, otherwise the bubble {0, 0, 0}.
  - The lane output is the oldest stage.
- Zero-delay lane (lane 0 in skew, lane ROWS-1 in deskew) is combinational:
  - OUT_DATA = acc ? IN_DATA : 0.
  - OUT_VALID = acc.
  - OUT_LAST = acc & IN_LAST.
- Bubbles always carry zero data, so the PE grid accumulates nothing from them.
- FSM has three states: IDLE, STREAM, DRAIN.
  - IDLE → STREAM on acc & ~IN_LAST.
  - IDLE or STREAM → DRAIN on acc & IN_LAST. The same edge loads cnt = ROWS-2.
  - DRAIN: cnt decrements on each adv edge.
  - DRAIN → IDLE on an adv edge while cnt == 0.
- DONE = (state == DRAIN) & (cnt == 0) & adv.
- cnt width is $clog2(ROWS).
- Delay registers, cnt and FSM state all hold while STALL is high.
- Reset (async or sync):
  - All delay stages are cleared to zero.
  - State = IDLE, cnt = 0.
  - All registered lane outputs read 0; DONE = 0; BUSY = 0; IN_READY = 0 while reset is asserted.
- Reset priority: SYNC_RST beats STALL, and STALL beats all data movement.

## Timing
- Latency: a beat accepted in cycle T appears on lane r in cycle T + delay(r) with no stalls; each STALL cycle adds one.
- With the last beat accepted in cycle T and no stalls:
  - DONE fires in cycle T+ROWS-1, the same cycle the maximum-delay lane presents its last tag.
  - IN_READY is low in cycles T+1 … T+ROWS-1.
  - IN_READY is high again in cycle T+ROWS.
- Back-to-back tiles are separated by exactly ROWS-1 closed cycles.
- STALL while cnt == 0 in DRAIN: DONE is held low, and it pulses on the first unstalled cycle.
- Reset mid-stream or mid-DRAIN discards in-flight beats; no DONE is produced for the aborted tile.
- Partially filled lanes never emit stale data; they emit zero bubbles.

## Structure
- Shared package `systolic_pkg`:
  - state enum `skew_state_t` {IDLE, STREAM, DRAIN};
  - function `lane_delay(r, rows, deskew)`;
  - localparam for the cnt width.
- Sub-module `skew_lane`, parameters WIDTH and DEPTH: a single delay line of {data, valid, last} with adv and clear inputs. DEPTH = 0 generates the combinational passthrough.
- The top level holds the FSM, the IN_READY/DONE logic and a generate loop of ROWS `skew_lane` instances.

## Test plan
- Skew, ROWS=4, no stall, beats k=0..3 with IN_DATA[r] = 16k+r and LAST on k=3 → lane r shows 16k+r in cycle k+r; OUT_LAST[3] and DONE in cycle 6; IN_READY low in cycles 4–6.
- Deskew, ROWS=4, same stimulus → lane 0 delayed 3 and lane 3 passthrough; all four lanes of beat 0 arrive diagonally reversed; DONE in cycle 6.
- STALL high for 2 cycles at cycle 2 → all OUT_* frozen, IN_READY=0, DONE moves to cycle 8, no data lost or duplicated.
- Bubbles: IN_VALID pattern 1,0,1 with LAST on the third beat → the gap lane outputs read data 0 with OUT_VALID 0 on its diagonal; DONE = T+3.
- SYNC_RST in DRAIN with cnt=1, then ASYNC_RST low mid-STREAM → next cycle all outputs 0, state IDLE, no DONE; the following tile runs normally.
- ROWS=2, single beat with IN_LAST in cycle 5 → lane 1 emits it in cycle 6 with DONE=1; IN_READY=0 only in cycle 6.
